// File: rtl/pwm_multi_top.sv
// Multi-channel PWM generator. Parameter frames arrive on a 32-bit
// AXI-Stream-like receive port. One shared restoring divider turns the
// requested frequency and duty into clock counts for one channel at a time.
module pwm_multi_top #(
  parameter int          PWM_NUM      = 5,
  parameter int          ID_PWM_PARAM = 0,
  parameter int unsigned CLK_FREQ     = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        rx_axis_udp_tdata,
  input  logic               rx_axis_udp_tvalid,
  input  logic               rx_axis_udp_tlast,
  input  logic [7:0]         rx_axis_udp_tuser,
  output logic [PWM_NUM-1:0] pwm
);

  localparam logic [7:0]  FRAME_ID = 8'(ID_PWM_PARAM);
  localparam logic [31:0] CLK_DIV  = 32'(CLK_FREQ);
  localparam logic [31:0] NUM_CH   = 32'(PWM_NUM);

  typedef enum logic [1:0] {S_IDLE, S_DIV_P, S_DIV_H, S_UPD} state_t;

  state_t      state;

  // Parser: word index (5 means past word 4) and a sticky wrong-ID flag.
  logic [2:0]  widx;
  logic        bad;
  logic [7:0]  ch_r;
  logic [31:0] freq_r;
  logic [6:0]  duty_r;

  // Job registers: held stable while the divider runs, so frames that are
  // dropped during a division cannot disturb it.
  logic [7:0]  job_ch;
  logic [31:0] job_freq;
  logic [6:0]  job_duty;
  logic        job_en;

  // Divider: partial remainder, shifting dividend/quotient, iteration count.
  logic [31:0] rem;
  logic [38:0] q;
  logic [5:0]  iter;
  logic [31:0] p_res;
  logic [31:0] h_res;

  // Per-channel settings and counters.
  logic [31:0] ch_period [PWM_NUM];
  logic [31:0] ch_high   [PWM_NUM];
  logic        ch_en     [PWM_NUM];
  logic [31:0] ch_cnt    [PWM_NUM];

  logic [31:0] divisor;
  logic [32:0] rem_sh;
  logic        ge;
  logic [32:0] rem_nx;
  logic [38:0] q_nx;
  logic [6:0]  duty_in;
  logic        beat_ok;
  logic        accept;
  logic        unused_bits;

  // One restoring-division step; the divisor is the frequency while computing
  // the period and 100 while scaling the period by the duty percentage.
  always_comb begin
    divisor = (state == S_DIV_H) ? 32'd100 : job_freq;
    rem_sh  = {rem, q[38]};
    ge      = (rem_sh >= {1'b0, divisor});
    rem_nx  = ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
    q_nx    = {q[37:0], ge};
  end

  // A remainder is always below the divisor, so its top bit is never needed.
  assign unused_bits = rem_nx[32];

  assign duty_in = (rx_axis_udp_tdata[6:0] > 7'd100) ? 7'd100 : rx_axis_udp_tdata[6:0];
  assign beat_ok = (rx_axis_udp_tuser == FRAME_ID);
  assign accept  = rx_axis_udp_tvalid && rx_axis_udp_tlast && (widx == 3'd4) &&
                   !bad && beat_ok && ({24'd0, ch_r} < NUM_CH) && (state == S_IDLE);

  // Frame parser plus the divider sequence: accept -> period -> high time -> update.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      state    <= S_IDLE;
      widx     <= 3'd0;
      bad      <= 1'b0;
      ch_r     <= 8'd0;
      freq_r   <= 32'd0;
      duty_r   <= 7'd0;
      job_ch   <= 8'd0;
      job_freq <= 32'd0;
      job_duty <= 7'd0;
      job_en   <= 1'b0;
      rem      <= 32'd0;
      q        <= 39'd0;
      iter     <= 6'd0;
      p_res    <= 32'd0;
      h_res    <= 32'd0;
    end else begin
      if (rx_axis_udp_tvalid) begin
        if (rx_axis_udp_tlast) begin
          widx <= 3'd0;
          bad  <= 1'b0;
        end else begin
          if (widx != 3'd5) widx <= widx + 3'd1;
          bad <= bad | !beat_ok;
        end
        case (widx)
          3'd0:    ch_r   <= rx_axis_udp_tdata[7:0];
          3'd1:    freq_r <= rx_axis_udp_tdata;
          3'd2:    duty_r <= duty_in;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            job_ch   <= ch_r;
            job_freq <= freq_r;
            job_duty <= duty_r;
            job_en   <= rx_axis_udp_tdata[0];
            rem      <= 32'd0;
            if (freq_r == 32'd0) begin
              p_res <= 32'd0;
              h_res <= 32'd0;
              state <= S_UPD;
            end else begin
              q     <= {CLK_DIV, 7'd0};
              iter  <= 6'd31;
              state <= S_DIV_P;
            end
          end
        end
        S_DIV_P: begin
          if (iter == 6'd0) begin
            p_res <= q_nx[31:0];
            q     <= 39'(q_nx[31:0]) * 39'(job_duty);
            rem   <= 32'd0;
            iter  <= 6'd38;
            state <= S_DIV_H;
          end else begin
            rem  <= rem_nx[31:0];
            q    <= q_nx;
            iter <= iter - 6'd1;
          end
        end
        S_DIV_H: begin
          rem  <= rem_nx[31:0];
          q    <= q_nx;
          iter <= iter - 6'd1;
          if (iter == 6'd0) begin
            h_res <= q_nx[31:0];
            state <= S_UPD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Channel bank: load the finished job into one channel, run all counters.
  always_ff @(posedge clk) begin
    // NOTE: these per-channel arrays are small register banks, not RAM, and
    // must come up as "disabled, period 0", so they are reset explicitly.
    if (rst) begin
      for (int i = 0; i < PWM_NUM; i++) begin
        ch_period[i] <= 32'd0;
        ch_high[i]   <= 32'd0;
        ch_en[i]     <= 1'b0;
        ch_cnt[i]    <= 32'd0;
      end
      pwm <= '0;
    end else begin
      for (int i = 0; i < PWM_NUM; i++) begin
        if (state == S_UPD && job_ch == i[7:0]) begin
          ch_period[i] <= p_res;
          ch_high[i]   <= h_res;
          ch_en[i]     <= job_en;
          ch_cnt[i]    <= 32'd0;
        end else if (!ch_en[i] || ch_period[i] < 32'd2) begin
          ch_cnt[i] <= 32'd0;
        end else if (ch_cnt[i] == ch_period[i] - 32'd1) begin
          ch_cnt[i] <= 32'd0;
        end else begin
          ch_cnt[i] <= ch_cnt[i] + 32'd1;
        end
        pwm[i] <= ch_en[i] && (ch_period[i] >= 32'd2) && (ch_cnt[i] < ch_high[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_top.sv
// Self-checking bench for pwm_multi_top. A per-channel model holds the
// frequency/duty arithmetic; each observation window compares the measured
// high time and rising-edge spacing of every output against it.
module tb_pwm_multi_top;

  localparam int     N   = 5;
  localparam int     ID  = 0;
  localparam longint CLK = 100000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  tdata;
  logic         tvalid;
  logic         tlast;
  logic [7:0]   tuser;
  logic [N-1:0] pwm;

  int errors = 0;
  int checks = 0;

  longint mp  [N];
  longint mh  [N];
  bit     men [N];
  logic [N-1:0] samp [8000];

  pwm_multi_top #(.PWM_NUM(N), .ID_PWM_PARAM(ID), .CLK_FREQ(CLK)) dut (
    .clk                (clk),
    .rst                (rst),
    .rx_axis_udp_tdata  (tdata),
    .rx_axis_udp_tvalid (tvalid),
    .rx_axis_udp_tlast  (tlast),
    .rx_axis_udp_tuser  (tuser),
    .pwm                (pwm)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mp[i] = 0; mh[i] = 0; men[i] = 0;
    end
  endtask

  // Period = clock / frequency, high time = period * clamped duty / 100.
  task automatic model_set(input int ch, input longint freq, input int duty, input bit en);
    longint d;
    d = (duty > 100) ? 100 : duty;
    mp[ch]  = (freq == 0) ? 0 : CLK / freq;
    mh[ch]  = mp[ch] * d / 100;
    men[ch] = en;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nbeats back-to-back beats; tlast on the final one.
  task automatic send(input int tu, input int ch, input longint freq, input int duty,
                      input bit en, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tuser  = 8'(tu);
      tlast  = (b == nbeats - 1);
      case (b)
        0:       tdata = ($urandom() & 32'hFFFF_FF00) | 32'(ch & 8'hFF);
        1:       tdata = 32'(freq);
        2:       tdata = ($urandom() & 32'hFFFF_FF80) | 32'(duty & 7'h7F);
        4:       tdata = ($urandom() & 32'hFFFF_FFFE) | 32'(en);
        default: tdata = $urandom();
      endcase
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Records a window of outputs and compares every channel with the model.
  task automatic measure(input string tag);
    longint maxp, w, hi, r1, r2;
    bit act;
    maxp = 0;
    for (int i = 0; i < N; i++)
      if (men[i] && mp[i] >= 2 && mp[i] > maxp) maxp = mp[i];
    w = 2 * maxp + 4;
    if (w < 200) w = 200;
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      samp[k] = pwm;
    end
    for (int i = 0; i < N; i++) begin
      act = men[i] && mp[i] >= 2;
      hi = 0;
      if (act) begin
        for (int k = 0; k < mp[i]; k++) hi += samp[k][i];
        check($sformatf("%s ch%0d high", tag, i), hi, mh[i]);
        if (mh[i] > 0 && mh[i] < mp[i]) begin
          r1 = -1; r2 = -1;
          for (int k = 1; k < w; k++)
            if (samp[k][i] && !samp[k-1][i]) begin
              if (r1 < 0) r1 = k;
              else if (r2 < 0) r2 = k;
            end
          check($sformatf("%s ch%0d period", tag, i), r2 - r1, mp[i]);
        end
      end else begin
        for (int k = 0; k < w; k++) hi += samp[k][i];
        check($sformatf("%s ch%0d idle", tag, i), hi, 0);
      end
    end
  endtask

  initial begin
    int ch, duty, p;
    longint freq;
    bit en;

    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0;
    model_reset();
    cycles(5);
    check("reset pwm", longint'(pwm), 0);
    rst = 1'b0;
    cycles(5);

    // Full duty on ch0; update must land within 80 cycles of tlast.
    send(ID, 0, 100000, 100, 1'b1, 5);
    cycles(80);
    check("ch0 latency", longint'(pwm[0]), 1);
    model_set(0, 100000, 100, 1'b1);
    measure("t1");

    // Three duties at 100 kHz plus duty 0 on ch4.
    send(ID, 1, 100000, 80, 1'b1, 5); cycles(90); model_set(1, 100000, 80, 1'b1);
    send(ID, 2, 100000, 50, 1'b1, 5); cycles(90); model_set(2, 100000, 50, 1'b1);
    send(ID, 3, 100000, 20, 1'b1, 5); cycles(90); model_set(3, 100000, 20, 1'b1);
    send(ID, 4, 100000, 0,  1'b1, 5); cycles(90); model_set(4, 100000, 0,  1'b1);
    measure("t2");

    // Reconfigure to 55 kHz.
    send(ID, 1, 55000, 80, 1'b1, 5); cycles(90); model_set(1, 55000, 80, 1'b1);
    send(ID, 2, 55000, 50, 1'b1, 5); cycles(90); model_set(2, 55000, 50, 1'b1);
    send(ID, 3, 55000, 20, 1'b1, 5); cycles(90); model_set(3, 55000, 20, 1'b1);
    measure("t3");

    // Disable every channel.
    for (int i = 0; i < N; i++) begin
      send(ID, i, 55000, 50, 1'b0, 5);
      cycles(80);
      check($sformatf("disable ch%0d", i), longint'(pwm[i]), 0);
      model_set(i, 55000, 50, 1'b0);
    end
    measure("t4");

    // Rejected frames: wrong ID, bad channel, short frame, overlong frame.
    send(ID + 1, 0, 100000, 50, 1'b1, 5); cycles(90);
    send(ID,     N, 100000, 50, 1'b1, 5); cycles(90);
    send(ID,     1, 100000, 50, 1'b1, 4); cycles(90);
    send(ID,     3, 100000, 50, 1'b1, 7); cycles(90);
    measure("reject");
    send(ID, 2, 100000, 50, 1'b1, 5); cycles(90); model_set(2, 100000, 50, 1'b1);
    measure("after reject");

    // Edge cases: zero frequency, period 1, duty clamp, busy drop.
    send(ID, 0, 0,        50,  1'b1, 5); cycles(90); model_set(0, 0,        50,  1'b1);
    send(ID, 1, 60000000, 50,  1'b1, 5); cycles(90); model_set(1, 60000000, 50,  1'b1);
    send(ID, 3, 100000,   120, 1'b1, 5); cycles(90); model_set(3, 100000,   120, 1'b1);
    send(ID, 4, 100000,   50,  1'b1, 5);
    cycles(3);
    send(ID, 2, 200000,   30,  1'b1, 5);
    cycles(90);
    model_set(4, 100000, 50, 1'b1);
    measure("edge");

    // Random configurations with short periods.
    for (int r = 0; r < 8; r++) begin
      ch   = $urandom_range(0, N - 1);
      p    = $urandom_range(20, 400);
      freq = CLK / p;
      duty = $urandom_range(0, 127);
      en   = 1'($urandom_range(0, 1));
      send(ID, ch, freq, duty, en, 5);
      cycles(90);
      model_set(ch, freq, duty, en);
      measure($sformatf("rand%0d", r));
    end

    // Reset in the middle of a division: nothing may be applied.
    send(ID, 2, 100000, 80, 1'b1, 5);
    cycles(20);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    model_reset();
    cycles(1);
    check("rst mid-div pwm", longint'(pwm), 0);
    cycles(100);
    measure("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
